// File: rtl/data_out_8_to_64_pkg.sv
// Shared constants and types for the 64<->8 byte serialiser pair.
package data_out_8_to_64_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int WORD_W         = 64;
  localparam int BYTE_W         = 8;
  localparam int CLK_HZ         = 50_000_000;
  localparam int BAUD           = 115200;

  // IDLE: no bytes held; COLLECT: 1..7 bytes of a word held.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Append a byte at the low end; earlier bytes move toward the MSB.
  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] word,
                                                  input logic [BYTE_W-1:0] b);
    return {word[WORD_W-BYTE_W-1:0], b};
  endfunction

endpackage

// File: rtl/data_out_8_to_64_interbyte_watchdog.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags the cycle
// in which the gap since the last clear reaches TIMEOUT_CYCLES-1 cycles.
module data_out_8_to_64_interbyte_watchdog #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // Counter saturates at the last value; expiry is flagged one cycle before
  // it would be reached, so a byte in that cycle still wins.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_EXP  = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] cnt;

  // Idle-cycle counter: cleared on any byte or while no word is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = enable && !clear && (cnt >= CNT_EXP);

endmodule

// File: rtl/data_out_8_to_64.sv
// Byte-to-word assembler: packs 8 consecutive received bytes (first = MSB)
// into a 64-bit word, dropping partial words after an inter-byte timeout.
// Handshake: byte_valid is a one-cycle strobe with no ready (no backpressure);
// data_64_valid is a one-cycle pulse and data_64 holds until the next word.
module data_out_8_to_64
  import data_out_8_to_64_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] data_8,
  input  logic              byte_valid,
  output logic [WORD_W-1:0] data_64,
  output logic              data_64_valid,
  output logic              busy,
  output logic              timeout_err
);

  state_t            state, state_next;
  logic [2:0]        byte_cnt, byte_cnt_next;
  logic [WORD_W-1:0] shreg, shreg_next;
  logic              load_word;
  logic              wd_clear, wd_enable, wd_expire;

  // Watchdog only runs while a partial word is held and no byte arrives.
  assign wd_clear  = (state == IDLE) || byte_valid;
  assign wd_enable = (state == COLLECT) && !byte_valid;

  data_out_8_to_64_interbyte_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (wd_clear),
    .enable(wd_enable),
    .expire(wd_expire)
  );

  // Next-state, byte count and shift register; a byte beats a same-cycle expiry.
  always_comb begin
    state_next    = state;
    byte_cnt_next = byte_cnt;
    shreg_next    = shreg;
    load_word     = 1'b0;
    case (state)
      IDLE: begin
        if (byte_valid) begin
          shreg_next    = shift_in(shreg, data_8);
          byte_cnt_next = 3'd1;
          state_next    = COLLECT;
        end
      end
      COLLECT: begin
        if (byte_valid) begin
          if (byte_cnt == 3'd7) begin
            load_word     = 1'b1;
            shreg_next    = '0;
            byte_cnt_next = 3'd0;
            state_next    = IDLE;
          end else begin
            shreg_next    = shift_in(shreg, data_8);
            byte_cnt_next = byte_cnt + 3'd1;
          end
        end else if (wd_expire) begin
          shreg_next    = '0;
          byte_cnt_next = 3'd0;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next    = IDLE;
        shreg_next    = '0;
        byte_cnt_next = 3'd0;
      end
    endcase
  end

  // State, count and partial-word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_cnt <= 3'd0;
      shreg    <= '0;
    end else begin
      state    <= state_next;
      byte_cnt <= byte_cnt_next;
      shreg    <= shreg_next;
    end
  end

  // Registered outputs: completed word, its valid pulse and the timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_64       <= '0;
      data_64_valid <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      data_64_valid <= load_word;
      timeout_err   <= wd_expire;
      if (load_word) begin
        data_64 <= shift_in(shreg, data_8);
      end
    end
  end

  assign busy = (state == COLLECT);

endmodule

// File: tb/tb_data_out_8_to_64.sv
// Directed bench for the byte-to-word assembler.
module tb_data_out_8_to_64;

  localparam int T = 20000;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_8;
  logic        byte_valid;
  logic [63:0] data_64;
  logic        data_64_valid;
  logic        busy;
  logic        timeout_err;

  int checks;
  int errors;
  int valid_cnt;
  int to_cnt;

  data_out_8_to_64 #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_8       (data_8),
    .byte_valid   (byte_valid),
    .data_64      (data_64),
    .data_64_valid(data_64_valid),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  // Clock generation, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled 2 ns after each rising edge.
  initial begin
    valid_cnt = 0;
    to_cnt    = 0;
  end
  always begin
    @(posedge clk);
    #2;
    if (rst_n) begin
      if (data_64_valid) valid_cnt++;
      if (timeout_err)   to_cnt++;
    end
  end

  // Driver tasks; both are entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    data_8     = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; byte_valid = 1'b0; data_8 = 8'h00;
    idle(3);
    checks++;
    if (data_64 !== 64'h0 || data_64_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got data_64=%h valid=%b busy=%b to=%b required all 0",
               data_64, data_64_valid, busy, timeout_err);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_spaced_word();
    logic [7:0] bytes [8] = '{8'h81, 8'hA3, 8'h4D, 8'h6F, 8'hF6, 8'hB2, 8'hC5, 8'h81};
    int v0, t0, bad_busy;
    v0 = valid_cnt; t0 = to_cnt; bad_busy = 0;
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i]);
      if (i < 7) begin
        if (busy !== 1'b1) bad_busy++;
        idle(4339);
        if (busy !== 1'b1) bad_busy++;
      end
    end
    checks++;
    if (data_64_valid !== 1'b1 || data_64 !== 64'h81A34D6FF6B2C581) begin
      errors++;
      $display("FAIL spaced_word: got valid=%b data_64=%h required 1 81a34d6ff6b2c581", data_64_valid, data_64);
    end
    checks++;
    if (bad_busy != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL spaced_busy: got %0d busy errors, final busy=%b required 0 and 0", bad_busy, busy);
    end
    idle(2);
    checks++;
    if (valid_cnt - v0 != 1 || to_cnt != t0) begin
      errors++;
      $display("FAIL spaced_pulses: got valid=%0d timeouts=%0d required 1 0", valid_cnt - v0, to_cnt - t0);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h01 + 8'(i));
      if (i == 6) begin
        checks++;
        if (data_64_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_early_valid: got %b required 0", data_64_valid);
        end
      end
    end
    checks++;
    if (data_64_valid !== 1'b1 || data_64 !== 64'h0102030405060708) begin
      errors++;
      $display("FAIL b2b_word1: got valid=%b data_64=%h required 1 0102030405060708", data_64_valid, data_64);
    end
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h11 + 8'(i));
      if (i == 0) begin
        checks++;
        if (data_64_valid !== 1'b0 || busy !== 1'b1 || data_64 !== 64'h0102030405060708) begin
          errors++;
          $display("FAIL b2b_gap: got valid=%b busy=%b data_64=%h required 0 1 0102030405060708",
                   data_64_valid, busy, data_64);
        end
      end
    end
    checks++;
    if (data_64_valid !== 1'b1 || data_64 !== 64'h1112131415161718) begin
      errors++;
      $display("FAIL b2b_word2: got valid=%b data_64=%h required 1 1112131415161718", data_64_valid, data_64);
    end
    idle(2);
    checks++;
    if (valid_cnt - v0 != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d required 2", valid_cnt - v0);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] bytes [8] = '{8'h81, 8'hA3, 8'h4D, 8'h6F, 8'hF6, 8'hB2, 8'hC5, 8'h81};
    int t0;
    t0 = to_cnt;
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    idle(T - 2);
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got busy=%b to=%b required 1 0", busy, timeout_err);
    end
    idle(1);
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || data_64 !== 64'h1112131415161718) begin
      errors++;
      $display("FAIL timeout_fire: got to=%b busy=%b data_64=%h required 1 0 1112131415161718",
               timeout_err, busy, data_64);
    end
    // The next byte lands one cycle after expiry and must start a new word.
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i]);
      if (i == 0) begin
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1 || to_cnt - t0 != 1) begin
          errors++;
          $display("FAIL timeout_pulse: got to=%b busy=%b pulses=%0d required 0 1 1",
                   timeout_err, busy, to_cnt - t0);
        end
      end
    end
    checks++;
    if (data_64_valid !== 1'b1 || data_64 !== 64'h81A34D6FF6B2C581) begin
      errors++;
      $display("FAIL timeout_recover: got valid=%b data_64=%h required 1 81a34d6ff6b2c581", data_64_valid, data_64);
    end
  endtask

  task automatic test_expiry_race();
    logic [7:0] rest [6] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h69};
    int t0;
    t0 = to_cnt;
    idle(2);
    send_byte(8'h5A);
    idle(T - 2);
    send_byte(8'hC3);
    idle(1);
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0 || to_cnt != t0) begin
      errors++;
      $display("FAIL race_accept: got busy=%b to=%b pulses=%0d required 1 0 0", busy, timeout_err, to_cnt - t0);
    end
    for (int i = 0; i < 6; i++) send_byte(rest[i]);
    checks++;
    if (data_64_valid !== 1'b1 || data_64 !== 64'h5AC30F1E2D3C4B69) begin
      errors++;
      $display("FAIL race_word: got valid=%b data_64=%h required 1 5ac30f1e2d3c4b69", data_64_valid, data_64);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] bytes [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    int v0;
    idle(2);
    send_byte(8'h99); send_byte(8'h88); send_byte(8'h77); send_byte(8'h66); send_byte(8'h55);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_64 !== 64'h0 || data_64_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got data_64=%h valid=%b busy=%b to=%b required all 0",
               data_64, data_64_valid, busy, timeout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    v0 = valid_cnt;
    for (int i = 0; i < 8; i++) send_byte(bytes[i]);
    checks++;
    if (data_64_valid !== 1'b1 || data_64 !== 64'hDEADBEEF01234567) begin
      errors++;
      $display("FAIL reset_word: got valid=%b data_64=%h required 1 deadbeef01234567", data_64_valid, data_64);
    end
    idle(3);
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL reset_pulses: got %0d required 1", valid_cnt - v0);
    end
  endtask

  task automatic test_ignore_data();
    int v0, t0, bad;
    v0 = valid_cnt; t0 = to_cnt; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      data_8 = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (busy !== 1'b0 || data_64 !== 64'hDEADBEEF01234567) bad++;
    end
    checks++;
    if (bad != 0 || valid_cnt != v0 || to_cnt != t0) begin
      errors++;
      $display("FAIL ignore_data: got %0d bad cycles, %0d valid, %0d timeouts required 0 0 0",
               bad, valid_cnt - v0, to_cnt - t0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_spaced_word();
    test_back_to_back();
    test_timeout();
    test_expiry_race();
    test_async_reset();
    test_ignore_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
